fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction prefetcher. It walks a fetch PC through instruction memory,
// issues one word request per cycle while the prefetch queue has room, and
// captures each response (valid one cycle after its request) into a small
// FIFO. The consumer pops instructions with a valid/ready handshake. A
// redirect flushes the queue, kills any in-flight response and restarts
// fetching at the word-aligned redirect target.
//
// Parameters
//   XLEN      instruction width in bits
//   PC_W      byte-address width of the PC / instruction memory
//   DEPTH     prefetch queue entries (power of two, 2..16)
//   RESET_PC  fetch PC loaded on reset (word aligned)
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   imem_req        fetch request issued this cycle
//   imem_addr       byte address of the request
//   imem_rdata      response data, valid one cycle after imem_req
//   redirect_valid  branch/jump redirect; flushes and re-steers fetch
//   redirect_pc     redirect target (bits [1:0] ignored)
//   out_valid       queue head holds an instruction
//   out_ready       consumer accepts the head
//   out_instr       head instruction
//   out_pc          address of the head instruction
//   count           current queue occupancy
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              PC_W     = 8,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [PC_W-1:0]          imem_addr,
   input  logic [XLEN-1:0]          imem_rdata,
   input  logic                     redirect_valid,
   input  logic [PC_W-1:0]          redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_instr,
   output logic [PC_W-1:0]          out_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [PC_W-1:0] pc;
   } entry_t;

   logic [PC_W-1:0]  fetch_pc_q,    fetch_pc_d;
   logic             inflight_q,    inflight_d;
   logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
   logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
   logic [CNT_W-1:0] count_q,       count_d;

   entry_t           mem_q [DEPTH];
   entry_t           head;
   logic             push;
   logic             pop;
   logic [CNT_W:0]   occupancy;

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (count_q != '0);
   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign count     = count_q;
   assign imem_addr = fetch_pc_q;

   // NOTE: every variable driven here gets a default first so no path through
   // the block leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      // The response to last cycle's request is the only push that can be
      // pending, so occupancy plus that flag is the full claim on the queue.
      // Pops this cycle are not credited, keeping the request path short.
      push      = inflight_q && !redirect_valid;
      pop       = out_valid && out_ready;
      occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      // reset gates the request combinationally so it drops without a clock.
      imem_req  = !reset && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));

      fetch_pc_d    = fetch_pc_q;
      inflight_d    = imem_req;
      inflight_pc_d = fetch_pc_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;

      if (redirect_valid) begin
         // A same-cycle pop still completes: the consumer took the head this
         // cycle, and everything else is dropped along with the in-flight word.
         fetch_pc_d = redirect_pc & ~PC_W'(3);
         inflight_d = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (imem_req) fetch_pc_d = fetch_pc_q + PC_W'(4);
         if (push)     wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         if (pop)      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   // NOTE: the queue storage is not reset; count_q gates every read, so stale
   // contents are never observable and the array can map to plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit (XLEN=32, PC_W=8, DEPTH=4, RESET_PC=0).
// The memory model returns a tagged word {24'hC0DE5A, addr} one cycle after
// each request. Inputs are driven at the falling edge and outputs sampled
// 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic [2:0]  count;

   int n_cmp;
   int n_err;

   fetch_unit #(
      .XLEN(32), .PC_W(8), .DEPTH(4), .RESET_PC(8'h00)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .count         (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_of(input logic [7:0] a);
      return {24'hC0DE5A, a};
   endfunction

   always @(posedge clk) imem_rdata <= word_of(imem_addr);

   // Pulse reset and return at a falling edge with reset just released.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b expected 0", imem_req); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
   endtask

   task automatic test_stream();
      logic [7:0] ea;
      do_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         ea = 8'(4 * k);
         n_cmp++; if (imem_req !== 1'b1 || imem_addr !== ea) begin n_err++; $display("FAIL stream_req[%0d]: got req=%0b addr=%0h expected req=1 addr=%0h", k, imem_req, imem_addr, ea); end
         n_cmp++; if (out_valid !== (k >= 2)) begin n_err++; $display("FAIL stream_valid[%0d]: got %0b expected %0b", k, out_valid, (k >= 2)); end
         if (k >= 2) begin
            ea = 8'(4 * (k - 2));
            n_cmp++; if (out_pc !== ea || out_instr !== word_of(ea)) begin n_err++; $display("FAIL stream_out[%0d]: got pc=%0h instr=%0h expected pc=%0h instr=%0h", k, out_pc, out_instr, ea, word_of(ea)); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      bit         req_tbl [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
      int         cnt_tbl [10] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 4};
      logic [7:0] ea;
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         n_cmp++; if (imem_req !== req_tbl[k]) begin n_err++; $display("FAIL bp_req[%0d]: got %0b expected %0b", k, imem_req, req_tbl[k]); end
         n_cmp++; if (count !== 3'(cnt_tbl[k])) begin n_err++; $display("FAIL bp_count[%0d]: got %0d expected %0d", k, count, cnt_tbl[k]); end
         if (req_tbl[k]) begin
            ea = 8'(4 * k);
            n_cmp++; if (imem_addr !== ea) begin n_err++; $display("FAIL bp_addr[%0d]: got %0h expected %0h", k, imem_addr, ea); end
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         ea = 8'(4 * k);
         n_cmp++; if (out_valid !== 1'b1 || out_pc !== ea || out_instr !== word_of(ea)) begin n_err++; $display("FAIL bp_drain[%0d]: got valid=%0b pc=%0h instr=%0h expected valid=1 pc=%0h instr=%0h", k, out_valid, out_pc, out_instr, ea, word_of(ea)); end
         @(negedge clk);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      out_ready = 1'b0;
      repeat (4) @(negedge clk);
      redirect_valid = 1'b1; redirect_pc = 8'h41; #1;
      n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL redir_pre_count: got %0d expected 3", count); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req_off: got %0b expected 0", imem_req); end
      @(negedge clk);
      redirect_valid = 1'b0; out_ready = 1'b1; #1;
      n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got count=%0d valid=%0b expected count=0 valid=0", count, out_valid); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin n_err++; $display("FAIL redir_target: got req=%0b addr=%0h expected req=1 addr=40", imem_req, imem_addr); end
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_killed: got valid=%0b pc=%0h expected valid=0", out_valid, out_pc); end
      @(negedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== word_of(8'h40)) begin n_err++; $display("FAIL redir_first: got valid=%0b pc=%0h instr=%0h expected valid=1 pc=40 instr=%0h", out_valid, out_pc, out_instr, word_of(8'h40)); end
   endtask

   task automatic test_redirect_pop();
      do_reset();
      out_ready = 1'b0;
      repeat (4) @(negedge clk);
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h80; #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 8'h00) begin n_err++; $display("FAIL rpop_head: got valid=%0b pc=%0h expected valid=1 pc=0", out_valid, out_pc); end
      @(negedge clk);
      redirect_valid = 1'b0; #1;
      n_cmp++; if (count !== 3'd0 || imem_addr !== 8'h80) begin n_err++; $display("FAIL rpop_flush: got count=%0d addr=%0h expected count=0 addr=80", count, imem_addr); end
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 8'h80) begin n_err++; $display("FAIL rpop_next: got valid=%0b pc=%0h expected valid=1 pc=80", out_valid, out_pc); end
      @(negedge clk); #1;
      n_cmp++; if (out_pc !== 8'h84) begin n_err++; $display("FAIL rpop_after: got pc=%0h expected 84", out_pc); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h90; #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL b2b_req0: got %0b expected 0", imem_req); end
      @(negedge clk);
      redirect_pc = 8'hA6; #1;
      n_cmp++; if (imem_req !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL b2b_req1: got req=%0b count=%0d expected req=0 count=0", imem_req, count); end
      @(negedge clk);
      redirect_valid = 1'b0; #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'hA4) begin n_err++; $display("FAIL b2b_target: got req=%0b addr=%0h expected req=1 addr=a4", imem_req, imem_addr); end
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 8'hA4) begin n_err++; $display("FAIL b2b_out: got valid=%0b pc=%0h expected valid=1 pc=a4", out_valid, out_pc); end
   endtask

   task automatic test_wrap();
      logic [7:0] addr_tbl [6] = '{8'hF8, 8'hFC, 8'h00, 8'h04, 8'h08, 8'h0C};
      do_reset();
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hF8;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         n_cmp++; if (imem_req !== 1'b1 || imem_addr !== addr_tbl[k]) begin n_err++; $display("FAIL wrap_addr[%0d]: got req=%0b addr=%0h expected req=1 addr=%0h", k, imem_req, imem_addr, addr_tbl[k]); end
         if (k >= 2) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== addr_tbl[k-2]) begin n_err++; $display("FAIL wrap_out[%0d]: got valid=%0b pc=%0h expected valid=1 pc=%0h", k, out_valid, out_pc, addr_tbl[k-2]); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (count !== 3'd2 || imem_req !== 1'b1) begin n_err++; $display("FAIL areset_pre: got count=%0d req=%0b expected count=2 req=1", count, imem_req); end
      #1 reset = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b0) begin n_err++; $display("FAIL areset_clear: got valid=%0b count=%0d req=%0b expected 0/0/0", out_valid, count, imem_req); end
      @(posedge clk); #1;
      n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL areset_hold: got count=%0d valid=%0b expected 0/0", count, out_valid); end
      @(negedge clk);
      reset = 1'b0; #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || count !== 3'd0) begin n_err++; $display("FAIL areset_first_req: got req=%0b addr=%0h count=%0d expected 1/0/0", imem_req, imem_addr, count); end
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || count !== 3'd1) begin n_err++; $display("FAIL areset_first_out: got valid=%0b pc=%0h count=%0d expected 1/0/1", out_valid, out_pc, count); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 8'h00;
      out_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_pop();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at %0t expected completion", $time);
      $fatal(1, "timeout");
   end

endmodule
